spi_mnrch_arb: RTL and testbench

Two-requester arbiter that shares one SPI_mnrch between the inertial interface (requester 0) and a second SPI client (requester 1, e.g. a config/debug port). It queues one command per requester and grants the bus round-robin. It sequences exactly one SPI transaction at a time and routes done back to the owner. A per-requester lock holds the grant across multi-transaction sequences (e.g. yaw low/high reads), and a watchdog releases a stale lock.

---
 rtl/spi_mnrch_arb.sv | 156 +++++++++++++++
 tb/tb_spi_mnrch_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mnrch_arb.sv
// spi_mnrch_arb: two-requester round-robin arbiter in front of one SPI_mnrch.
// Each requester gets a one-deep command holding register. The bus is granted
// round-robin, and one SPI transaction runs at a time. A per-requester lock keeps
// the grant across multi-transaction sequences, and a watchdog frees a lock that
// goes stale.
module spi_mnrch_arb #(
  parameter int TMO_W    = 12,
  parameter int FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt0,
  input  logic [15:0] cmd0,
  input  logic        lock0,
  output logic        done0,
  output logic [15:0] rspns0,
  input  logic        wrt1,
  input  logic [15:0] cmd1,
  input  logic        lock1,
  output logic        done1,
  output logic [15:0] rspns1,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rspns,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        tmo_err,
  output logic        ovr_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, LOCKED} state_t;

  // The watchdog fires on the cycle when the counter reads limit-1.
  // Counting starts at 0 on the first LOCKED cycle, so the firing cycle
  // is the limit-th idle cycle.
  localparam logic [TMO_W-1:0] WD_LAST = (FAST_SIM != 0) ? TMO_W'(62)
                                                         : {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [1:0]        pend_q, pend_d;
  logic [15:0]       hold0_q, hold0_d;
  logic [15:0]       hold1_q, hold1_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic [15:0]       spi_cmd_q, spi_cmd_d;
  logic [1:0]        clr_pend;
  logic              lock_own;
  logic              wd_fire;

  assign lock_own = owner_q ? lock1 : lock0;
  assign wd_fire  = (state_q == LOCKED) && !pend_q[owner_q] && lock_own &&
                    (wdog_q == WD_LAST);

  // State and datapath registers; last_owner resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 2'b00;
      hold0_q   <= 16'h0000;
      hold1_q   <= 16'h0000;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      wdog_q    <= '0;
      spi_cmd_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      hold0_q   <= hold0_d;
      hold1_q   <= hold1_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      spi_cmd_q <= spi_cmd_d;
    end
  end

  // Next-state logic: arbitration, transaction sequencing, lock hold and watchdog
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    spi_cmd_d = spi_cmd_q;
    clr_pend  = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          owner_d   = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          spi_cmd_d = owner_d ? hold1_q : hold0_q;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        clr_pend[owner_q] = 1'b1;
        state_d           = BUSY;
      end
      BUSY: begin
        if (spi_done) begin
          if (lock_own) begin
            state_d = LOCKED;
            wdog_d  = '0;
          end else begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      LOCKED: begin
        if (pend_q[owner_q]) begin
          // The owner's next command goes straight out without re-arbitration
          spi_cmd_d = owner_q ? hold1_q : hold0_q;
          state_d   = ISSUE;
        end else if (!lock_own || wd_fire) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending latches: accept a strobe only into an empty slot; ISSUE frees the owner's slot
  always_comb begin
    pend_d  = pend_q & ~clr_pend;
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    if (wrt0 && !pend_q[0]) begin
      pend_d[0] = 1'b1;
      hold0_d   = cmd0;
    end
    if (wrt1 && !pend_q[1]) begin
      pend_d[1] = 1'b1;
      hold1_d   = cmd1;
    end
  end

  // Outputs decoded from registered state; done is routed combinationally to the owner
  always_comb begin
    spi_wrt = (state_q == ISSUE);
    spi_cmd = spi_cmd_q;
    busy    = (state_q != IDLE);
    gnt     = 2'b00;
    if (state_q != IDLE) gnt = owner_q ? 2'b10 : 2'b01;
    done0   = (state_q == BUSY) && spi_done && !owner_q;
    done1   = (state_q == BUSY) && spi_done && owner_q;
    rspns0  = spi_rspns;
    rspns1  = spi_rspns;
    tmo_err = wd_fire;
    ovr_err = (wrt0 && pend_q[0]) || (wrt1 && pend_q[1]);
  end

endmodule

// File: tb/tb_spi_mnrch_arb.sv
// Self-checking bench for spi_mnrch_arb. Expected SPI commands are queued in
// the order they should be issued and compared whenever spi_wrt appears.
module tb_spi_mnrch_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt0, lock0, wrt1, lock1;
  logic [15:0] cmd0, cmd1;
  logic        done0, done1;
  logic [15:0] rspns0, rspns1;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rspns;
  logic [1:0]  gnt;
  logic        busy, tmo_err, ovr_err;

  int checks   = 0;
  int failures = 0;
  int wrt_cnt  = 0;
  logic [15:0] exp_q[$];

  spi_mnrch_arb #(.TMO_W(12), .FAST_SIM(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wrt0(wrt0), .cmd0(cmd0), .lock0(lock0), .done0(done0), .rspns0(rspns0),
    .wrt1(wrt1), .cmd1(cmd1), .lock1(lock1), .done1(done1), .rspns1(rspns1),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rspns(spi_rspns),
    .gnt(gnt), .busy(busy), .tmo_err(tmo_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every issued SPI command must match the next expected one
  always @(negedge clk) begin
    if (rst_n && spi_wrt) begin
      wrt_cnt++;
      if (exp_q.size() == 0) chk("unexpected_spi_wrt", spi_wrt, 1'b0);
      else                   chk("spi_cmd", spi_cmd, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    wrt0 = 0; wrt1 = 0; lock0 = 0; lock1 = 0; cmd0 = 0; cmd1 = 0;
    spi_done = 0; spi_rspns = 16'h0000;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) until spi_wrt is seen at a negedge
  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!spi_wrt && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!spi_wrt) chk({tag, "_timeout"}, spi_wrt, 1'b1);
  endtask

  // Called at the negedge of the ISSUE cycle: complete the transaction
  task automatic do_done(input logic [1:0] own, input logic [15:0] rsp);
    @(posedge clk); #1;
    spi_rspns = rsp;
    spi_done  = 1'b1;
    @(negedge clk);
    chk("spi_wrt_one_clk", spi_wrt, 1'b0);
    chk("done0", done0, own[0]);
    chk("done1", done1, own[1]);
    chk("rspns", own[1] ? rspns1 : rspns0, rsp);
    @(posedge clk); #1;
    spi_done = 1'b0;
  endtask

  initial begin
    int k;
    int cnt0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_spi_wrt", spi_wrt, 1'b0);
    chk("rst_spi_cmd", spi_cmd, 16'h0000);
    chk("rst_done", {done0, done1}, 2'b00);
    chk("rst_err", {tmo_err, ovr_err}, 2'b00);

    // Single request: issue exactly two cycles after the strobe
    @(posedge clk); #1;
    exp_q.push_back(16'hA600);
    wrt0 = 1; cmd0 = 16'hA600;
    @(posedge clk); #1;
    wrt0 = 0;
    @(negedge clk);
    chk("single_lat_t1", spi_wrt, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_lat_t2", spi_wrt, 1'b1);
    chk("single_gnt", gnt, 2'b01);
    chk("single_busy", busy, 1'b1);
    do_done(2'b01, 16'hC3C3);
    @(negedge clk);
    chk("single_idle_gnt", gnt, 2'b00);
    chk("single_idle_busy", busy, 1'b0);

    // Simultaneous after reset: requester 0 first, then 1
    do_reset();
    exp_q.push_back(16'h0D02);
    exp_q.push_back(16'h1160);
    wrt0 = 1; cmd0 = 16'h0D02; wrt1 = 1; cmd1 = 16'h1160;
    @(posedge clk); #1;
    wrt0 = 0; wrt1 = 0;
    wait_issue("sim_a");
    chk("sim_a_gnt", gnt, 2'b01);
    do_done(2'b01, 16'h1111);
    wait_issue("sim_b");
    chk("sim_b_gnt", gnt, 2'b10);
    do_done(2'b10, 16'h2222);
    // Repeat: requester 1 was served last, so requester 0 goes first again
    exp_q.push_back(16'h0D02);
    exp_q.push_back(16'h1160);
    wrt0 = 1; cmd0 = 16'h0D02; wrt1 = 1; cmd1 = 16'h1160;
    @(posedge clk); #1;
    wrt0 = 0; wrt1 = 0;
    wait_issue("rep_a");
    chk("rep_a_gnt", gnt, 2'b01);
    do_done(2'b01, 16'h3333);
    wait_issue("rep_b");
    chk("rep_b_gnt", gnt, 2'b10);
    do_done(2'b10, 16'h4444);
    // Serve requester 0 alone, then a tie must go to requester 1
    exp_q.push_back(16'h0A0A);
    wrt0 = 1; cmd0 = 16'h0A0A;
    @(posedge clk); #1;
    wrt0 = 0;
    wait_issue("solo");
    do_done(2'b01, 16'h5555);
    exp_q.push_back(16'h1160);
    exp_q.push_back(16'h0D02);
    wrt0 = 1; cmd0 = 16'h0D02; wrt1 = 1; cmd1 = 16'h1160;
    @(posedge clk); #1;
    wrt0 = 0; wrt1 = 0;
    wait_issue("tie_a");
    chk("tie_a_gnt", gnt, 2'b10);
    do_done(2'b10, 16'h6666);
    wait_issue("tie_b");
    chk("tie_b_gnt", gnt, 2'b01);
    do_done(2'b01, 16'h7777);

    // Lock sequence: A700 strobed in the done cycle beats pending 1440
    lock0 = 1;
    exp_q.push_back(16'hA600);
    exp_q.push_back(16'hA700);
    exp_q.push_back(16'h1440);
    wrt0 = 1; cmd0 = 16'hA600;
    @(posedge clk); #1;
    wrt0 = 0;
    wrt1 = 1; cmd1 = 16'h1440;
    @(posedge clk); #1;
    wrt1 = 0;
    wait_issue("lock_a");
    chk("lock_a_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    spi_done = 1; spi_rspns = 16'h00AB;
    wrt0 = 1; cmd0 = 16'hA700;
    @(negedge clk);
    chk("lock_done0", done0, 1'b1);
    chk("lock_done1", done1, 1'b0);
    @(posedge clk); #1;
    spi_done = 0; wrt0 = 0;
    @(negedge clk);
    chk("lock_hold_gnt", gnt, 2'b01);
    chk("lock_d1_wrt", spi_wrt, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lock_d2_wrt", spi_wrt, 1'b1);
    do_done(2'b01, 16'h00CD);
    lock0 = 0;
    wait_issue("lock_b");
    chk("lock_b_gnt", gnt, 2'b10);
    do_done(2'b10, 16'h00EF);

    // Watchdog: lock1 held with no further wrt1
    lock1 = 1;
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    wrt1 = 1; cmd1 = 16'h2222;
    @(posedge clk); #1;
    wrt1 = 0;
    wait_issue("wd_a");
    chk("wd_a_gnt", gnt, 2'b10);
    do_done(2'b10, 16'h0102);
    wrt0 = 1; cmd0 = 16'h3333;
    @(posedge clk); #1;
    wrt0 = 0;
    k = 2;
    while (k < 200) begin
      @(negedge clk);
      if (tmo_err) break;
      k++;
      @(posedge clk); #1;
    end
    chk("wd_latency", k, 63);
    chk("wd_gnt_at_tmo", gnt, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_tmo_one_clk", tmo_err, 1'b0);
    chk("wd_t1_wrt", spi_wrt, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_t2_wrt", spi_wrt, 1'b1);
    chk("wd_b_gnt", gnt, 2'b01);
    lock1 = 0;
    do_done(2'b01, 16'h0304);

    // Overflow: second wrt1 while pending is dropped
    exp_q.push_back(16'h4444);
    exp_q.push_back(16'h1160);
    wrt0 = 1; cmd0 = 16'h4444;
    @(posedge clk); #1;
    wrt0 = 0;
    wait_issue("ovr_a");
    @(posedge clk); #1;
    wrt1 = 1; cmd1 = 16'h1160;
    @(negedge clk);
    chk("ovr_first", ovr_err, 1'b0);
    @(posedge clk); #1;
    cmd1 = 16'h0D02;
    @(negedge clk);
    chk("ovr_second", ovr_err, 1'b1);
    @(posedge clk); #1;
    wrt1 = 0;
    spi_done = 1; spi_rspns = 16'h0506;
    @(negedge clk);
    chk("ovr_done0", done0, 1'b1);
    chk("ovr_pulse_end", ovr_err, 1'b0);
    @(posedge clk); #1;
    spi_done = 0;
    wait_issue("ovr_b");
    chk("ovr_b_gnt", gnt, 2'b10);
    do_done(2'b10, 16'h0708);
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_queue_drained", exp_q.size(), 0);

    // Reset mid-BUSY with a pending request
    exp_q.push_back(16'h5555);
    wrt0 = 1; cmd0 = 16'h5555;
    @(posedge clk); #1;
    wrt0 = 0;
    wait_issue("rst_a");
    @(posedge clk); #1;
    wrt1 = 1; cmd1 = 16'h6666;
    @(negedge clk);
    chk("rst_mid_busy", busy, 1'b1);
    rst_n = 0; wrt1 = 0;
    #1;
    chk("rst_async_gnt", gnt, 2'b00);
    chk("rst_async_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    cnt0 = wrt_cnt;
    spi_done = 1; spi_rspns = 16'h0909;
    @(negedge clk);
    chk("late_done", {done0, done1}, 2'b00);
    @(posedge clk); #1;
    spi_done = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_pending_cleared", wrt_cnt - cnt0, 0);
    chk("rst_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
